// File: rtl/rgb_to_yuv_converter_pkg.sv
// Shared constants, BT.601 studio-range coefficients and state encoding
// for the planar RGB-to-YUV frame converter.
package rgb_to_yuv_converter_pkg;

  localparam int ADDR_W = 18;
  localparam int WORD_W = 16;
  localparam int ACC_W  = 18;

  localparam logic signed [ACC_W-1:0] Y_R = 18'sd66;
  localparam logic signed [ACC_W-1:0] Y_G = 18'sd129;
  localparam logic signed [ACC_W-1:0] Y_B = 18'sd25;
  localparam logic signed [ACC_W-1:0] U_R = -18'sd38;
  localparam logic signed [ACC_W-1:0] U_G = -18'sd74;
  localparam logic signed [ACC_W-1:0] U_B = 18'sd112;
  localparam logic signed [ACC_W-1:0] V_R = 18'sd112;
  localparam logic signed [ACC_W-1:0] V_G = -18'sd94;
  localparam logic signed [ACC_W-1:0] V_B = -18'sd18;

  localparam logic signed [ACC_W-1:0] Y_OFS  = 18'sd16;
  localparam logic signed [ACC_W-1:0] UV_OFS = 18'sd128;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD_R = 4'd1,
    RD_G = 4'd2,
    RD_B = 4'd3,
    CALC = 4'd4,
    WR_Y = 4'd5,
    WR_U = 4'd6,
    WR_V = 4'd7,
    DONE = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    COMP_Y = 2'd0,
    COMP_U = 2'd1,
    COMP_V = 2'd2
  } comp_t;

endpackage

// File: rtl/rgb_to_yuv_converter_if.sv
// Controller handshake and frame-memory port of the RGB-to-YUV converter.
interface rgb_to_yuv_converter_if;
  import rgb_to_yuv_converter_pkg::*;

  logic              start;
  logic [WORD_W-1:0] R_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [WORD_W-1:0] W_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, R_data,
    output mem_addr, mem_rd, mem_wr, W_data, busy, done
  );

  modport slave (
    output start, R_data,
    input  mem_addr, mem_rd, mem_wr, W_data, busy, done
  );

endinterface

// File: rtl/rgb_yuv_pixel_calc.sv
// Combinational single-pixel RGB -> Y/U/V component with saturation.
// RGB2YUV_ROUND_EN selects round-to-nearest; otherwise floor truncation.
module rgb_yuv_pixel_calc
  import rgb_to_yuv_converter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] b,
  input  comp_t             sel,
  output logic [DATA_W-1:0] result
);

`ifdef RGB2YUV_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = 18'sd128;
`else
  localparam logic signed [ACC_W-1:0] RND = 18'sd0;
`endif

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] t;
    t = acc + RND;
    return t >>> 8;
  endfunction

  function automatic logic [DATA_W-1:0] sat_u8(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])
      return '0;
    else if (v > SAT_MAX)
      return '1;
    else
      return v[DATA_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] rs, gs, bs;
  logic signed [ACC_W-1:0] kr, kg, kb, ofs;
  logic signed [ACC_W-1:0] acc, scaled;

  assign rs = $signed({{(ACC_W-DATA_W){1'b0}}, r});
  assign gs = $signed({{(ACC_W-DATA_W){1'b0}}, g});
  assign bs = $signed({{(ACC_W-DATA_W){1'b0}}, b});

  always_comb begin
    kr  = Y_R;
    kg  = Y_G;
    kb  = Y_B;
    ofs = Y_OFS;
    case (sel)
      COMP_U: begin kr = U_R; kg = U_G; kb = U_B; ofs = UV_OFS; end
      COMP_V: begin kr = V_R; kg = V_G; kb = V_B; ofs = UV_OFS; end
      default: ;
    endcase
  end

  // Worst-case magnitude stays well inside 18 signed bits, so no guard bits.
  assign acc    = kr * rs + kg * gs + kb * bs;
  assign scaled = round_shift(acc) + ofs;
  assign result = sat_u8(scaled);

endmodule

// File: rtl/rgb_to_yuv_converter.sv
// Frame-level planar RGB -> YUV converter: 7-state-per-pair memory sequencer
// driving two pixel calculators (odd/even). Rounding mode: RGB2YUV_ROUND_EN.
module rgb_to_yuv_converter
  import rgb_to_yuv_converter_pkg::*;
#(
  parameter int unsigned PAIRS  = 38400,
  parameter int unsigned R_BASE = 0,
  parameter int unsigned G_BASE = 38400,
  parameter int unsigned B_BASE = 76800,
  parameter int unsigned Y_BASE = 115200,
  parameter int unsigned U_BASE = 153600,
  parameter int unsigned V_BASE = 192000
) (
  input  logic                    clk,
  input  logic                    rst,
  rgb_to_yuv_converter_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PAIRS - 1);
  localparam logic [ADDR_W-1:0] R_ADDR   = ADDR_W'(R_BASE);
  localparam logic [ADDR_W-1:0] G_ADDR   = ADDR_W'(G_BASE);
  localparam logic [ADDR_W-1:0] B_ADDR   = ADDR_W'(B_BASE);
  localparam logic [ADDR_W-1:0] Y_ADDR   = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] U_ADDR   = ADDR_W'(U_BASE);
  localparam logic [ADDR_W-1:0] V_ADDR   = ADDR_W'(V_BASE);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        r_odd, r_even, g_odd, g_even, b_odd, b_even;
  logic [7:0]        res_odd, res_even;
  comp_t             sel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RD_R;
      RD_R:    state_nxt = RD_G;
      RD_G:    state_nxt = RD_B;
      RD_B:    state_nxt = CALC;
      CALC:    state_nxt = WR_Y;
      WR_Y:    state_nxt = WR_U;
      WR_U:    state_nxt = WR_V;
      WR_V:    state_nxt = (idx == LAST_IDX) ? DONE : RD_R;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so each plane is captured in
  // the state after its read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      r_odd  <= '0;
      r_even <= '0;
      g_odd  <= '0;
      g_even <= '0;
      b_odd  <= '0;
      b_even <= '0;
    end else begin
      case (state)
        RD_G: {r_odd, r_even} <= bus.R_data;
        RD_B: {g_odd, g_even} <= bus.R_data;
        CALC: {b_odd, b_even} <= bus.R_data;
        WR_V: if (idx != LAST_IDX) idx <= idx + 1'b1;
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state)
      WR_U:    sel = COMP_U;
      WR_V:    sel = COMP_V;
      default: sel = COMP_Y;
    endcase
  end

  rgb_yuv_pixel_calc #(.DATA_W(8)) u_calc_odd (
    .r      (r_odd),
    .g      (g_odd),
    .b      (b_odd),
    .sel    (sel),
    .result (res_odd)
  );

  rgb_yuv_pixel_calc #(.DATA_W(8)) u_calc_even (
    .r      (r_even),
    .g      (g_even),
    .b      (b_even),
    .sel    (sel),
    .result (res_even)
  );

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.W_data   = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      RD_R: begin bus.busy = 1'b1; bus.mem_rd = 1'b1; bus.mem_addr = R_ADDR + idx; end
      RD_G: begin bus.busy = 1'b1; bus.mem_rd = 1'b1; bus.mem_addr = G_ADDR + idx; end
      RD_B: begin bus.busy = 1'b1; bus.mem_rd = 1'b1; bus.mem_addr = B_ADDR + idx; end
      CALC: bus.busy = 1'b1;
      WR_Y: begin
        bus.busy = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = Y_ADDR + idx;
        bus.W_data = {res_odd, res_even};
      end
      WR_U: begin
        bus.busy = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = U_ADDR + idx;
        bus.W_data = {res_odd, res_even};
      end
      WR_V: begin
        bus.busy = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = V_ADDR + idx;
        bus.W_data = {res_odd, res_even};
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rgb_to_yuv_converter.sv
// Bench for rgb_to_yuv_converter: 4-pair frames, directed and random pixels,
// cycle-by-cycle strobe/data comparison against a plain-arithmetic model.
module tb_rgb_to_yuv_converter;

  localparam int PAIRS  = 4;
  localparam int R_BASE = 0;
  localparam int G_BASE = 38400;
  localparam int B_BASE = 76800;
  localparam int Y_BASE = 115200;
  localparam int U_BASE = 153600;
  localparam int V_BASE = 192000;
  localparam int FRAME_CYC = 7 * PAIRS + 1;

`ifdef RGB2YUV_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_to_yuv_converter_if bus();

  rgb_to_yuv_converter #(.PAIRS(PAIRS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:262143];
  logic [15:0] r_w [PAIRS];
  logic [15:0] g_w [PAIRS];
  logic [15:0] b_w [PAIRS];
  logic [15:0] dconst [PAIRS][3];

  int n_tot = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    if (bus.mem_rd) bus.R_data <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int floor_div256(input int a);
    int q;
    q = a / 256;
    if (a < 0 && (a % 256) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] ref_pix(input int r, input int g, input int b, input int comp);
    int v;
    case (comp)
      0:       v = floor_div256(66 * r + 129 * g + 25 * b + RND) + 16;
      1:       v = floor_div256(-38 * r - 74 * g + 112 * b + RND) + 128;
      default: v = floor_div256(112 * r - 94 * g - 18 * b + RND) + 128;
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  function automatic logic [15:0] ref_word(input int p, input int comp);
    logic [15:0] rr, gg, bb;
    rr = r_w[p]; gg = g_w[p]; bb = b_w[p];
    return {ref_pix(int'(rr[15:8]), int'(gg[15:8]), int'(bb[15:8]), comp),
            ref_pix(int'(rr[7:0]),  int'(gg[7:0]),  int'(bb[7:0]),  comp)};
  endfunction

  // {busy, done, mem_rd, mem_wr, mem_addr, W_data} expected in cycle c after start.
  function automatic logic [63:0] exp_vec(input int c);
    int p, ph;
    logic [17:0] addr;
    logic [15:0] wd;
    logic rd, wr;
    if (c == FRAME_CYC) return {26'b0, 1'b0, 1'b1, 36'b0};
    p  = (c - 1) / 7;
    ph = (c - 1) % 7;
    rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
    case (ph)
      0: begin rd = 1'b1; addr = 18'(R_BASE + p); end
      1: begin rd = 1'b1; addr = 18'(G_BASE + p); end
      2: begin rd = 1'b1; addr = 18'(B_BASE + p); end
      4: begin wr = 1'b1; addr = 18'(Y_BASE + p); wd = ref_word(p, 0); end
      5: begin wr = 1'b1; addr = 18'(U_BASE + p); wd = ref_word(p, 1); end
      6: begin wr = 1'b1; addr = 18'(V_BASE + p); wd = ref_word(p, 2); end
      default: ;
    endcase
    return {26'b0, 1'b1, 1'b0, rd, wr, addr, wd};
  endfunction

  function automatic logic [63:0] obs();
    return {26'b0, bus.busy, bus.done, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.W_data};
  endfunction

  task automatic load_pair(input int p, input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    r_w[p] = r; g_w[p] = g; b_w[p] = b;
    mem[R_BASE + p] = r;
    mem[G_BASE + p] = g;
    mem[B_BASE + p] = b;
  endtask

  task automatic load_random();
    for (int p = 0; p < PAIRS; p++)
      load_pair(p, 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic run_frame(input string name, input bit directed, input int mid_start, input int abort_at);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 1; c <= FRAME_CYC; c++) begin
      chk($sformatf("%s_cyc%0d", name, c), obs(), exp_vec(c));
      if (directed && c < FRAME_CYC && ((c - 1) % 7) >= 4)
        chk($sformatf("%s_const_p%0d_c%0d", name, (c - 1) / 7, ((c - 1) % 7) - 4),
            {48'b0, bus.W_data}, {48'b0, dconst[(c - 1) / 7][((c - 1) % 7) - 4]});
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk($sformatf("%s_abort", name), obs(), 64'b0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk($sformatf("%s_abort_idle%0d", name, k), obs(), 64'b0);
        end
        return;
      end
      if (c == mid_start) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_post%0d", name, k), obs(), 64'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    load_pair(0, 16'h0000, 16'h0000, 16'h0000);
    load_pair(1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    load_pair(2, 16'hFF00, 16'h0000, 16'h0000);
    load_pair(3, 16'h0000, 16'h0000, 16'h00FF);
    dconst[0][0] = 16'h1010; dconst[0][1] = 16'h8080; dconst[0][2] = 16'h8080;
    dconst[1][0] = 16'hEBEB; dconst[1][1] = 16'h8080; dconst[1][2] = 16'h8080;
`ifdef RGB2YUV_ROUND_EN
    dconst[2][0] = 16'h5210; dconst[2][1] = 16'h5A80; dconst[2][2] = 16'hF080;
    dconst[3][0] = 16'h1029; dconst[3][1] = 16'h80F0; dconst[3][2] = 16'h806E;
`else
    dconst[2][0] = 16'h5110; dconst[2][1] = 16'h5A80; dconst[2][2] = 16'hEF80;
    dconst[3][0] = 16'h1028; dconst[3][1] = 16'h80EF; dconst[3][2] = 16'h806E;
`endif

    repeat (3) @(negedge clk);
    chk("reset_outputs", obs(), 64'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", obs(), 64'b0);

    run_frame("directed", 1'b1, 10, 0);

    load_random();
    run_frame("rand_a", 1'b0, 3, 0);

    load_random();
    run_frame("abort", 1'b0, 0, 2 * 7 + 6);

    load_random();
    run_frame("restart", 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
